// File: rtl/bram_burst_packer.sv
// -----------------------------------------------------------------------------
// bram_burst_packer
//
// Multi-channel packer. It sits between the pipe-in endpoint streams (okClk
// domain) and the wide write ports of the data/weight/bias BRAMs. Each channel
// collects ELEM_W-bit elements from 32-bit pipe words into a line of BURST_LEN
// elements. Element 0 sits at the LSBs of the line. A full line, or a partial
// line released by flush (zero-padded), is written to that channel's BRAM. The
// write address increments by itself and wraps after cfg_limit.
//
// Ports
//   clk           pipe-side clock (okClk)
//   rst           asynchronous, active-low reset
//   soft_clr      synchronous clear of all channels; overrides wr_en and flush
//   wr_en         [NUM_CH] per-channel pipe write strobe
//   din           [NUM_CH*32] pipe words, channel c at [32c+31:32c]
//   flush         pulse: emit every non-empty partial line, zero-padded
//   cfg_limit     [NUM_CH*ADDR_W] last valid address per channel
//   ram_we        [NUM_CH] one-cycle BRAM write strobe
//   ram_addr      [NUM_CH*ADDR_W] BRAM write address, valid while ram_we=1
//   ram_data      [NUM_CH*ELEM_W*BURST_LEN] line data, element 0 at LSBs
//   elem_cnt      [NUM_CH*8] elements held in the current partial line
//   wrap_flag     [NUM_CH] sticky: the address wrapped past cfg_limit
//   lines_written [NUM_CH*16] lines written since clear, saturating at 0xFFFF
//
// PACK_MODE=0 takes din[ELEM_W-1:0] from each word. PACK_MODE=1 takes two
// elements per word: [ELEM_W-1:0] first, then [16+ELEM_W-1:16]. BURST_LEN
// must be even in PACK_MODE=1, so that a line always fills exactly.
// -----------------------------------------------------------------------------
module bram_burst_packer #(
  parameter int NUM_CH    = 3,
  parameter int ELEM_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 13,
  parameter int PACK_MODE = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              soft_clr,
  input  logic [NUM_CH-1:0]                 wr_en,
  input  logic [NUM_CH*32-1:0]              din,
  input  logic                              flush,
  input  logic [NUM_CH*ADDR_W-1:0]          cfg_limit,
  output logic [NUM_CH-1:0]                 ram_we,
  output logic [NUM_CH*ADDR_W-1:0]          ram_addr,
  output logic [NUM_CH*ELEM_W*BURST_LEN-1:0] ram_data,
  output logic [NUM_CH*8-1:0]               elem_cnt,
  output logic [NUM_CH-1:0]                 wrap_flag,
  output logic [NUM_CH*16-1:0]              lines_written
);

  localparam int LINE_W = ELEM_W * BURST_LEN;
  localparam int CNT_W  = $clog2(BURST_LEN + 1);

  // All per-channel state lives in one record. The accumulator (acc) is kept
  // separate from the holding register (line), so that elements arriving while
  // ram_we is high start the next line and never disturb the data being
  // written.
  typedef struct packed {
    logic [LINE_W-1:0] acc;    // partial line being collected
    logic [CNT_W-1:0]  cnt;    // elements in acc, 0..BURST_LEN-1
    logic [LINE_W-1:0] line;   // line presented on ram_data
    logic [ADDR_W-1:0] addr;   // address presented on ram_addr
    logic              we;     // write strobe
    logic              wrap;   // sticky wrap status
    logic [15:0]       lines;  // saturating line counter
  } ch_state_t;

  ch_state_t st_q [NUM_CH];
  ch_state_t st_d [NUM_CH];

  // Bits of din that the selected packing mode never looks at.
  logic unused_din;
  assign unused_din = ^din;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    logic [LINE_W-1:0] acc;
    int                cnt;
    // NOTE: every variable assigned here gets a value before any branch, so
    // no path can leave one unassigned and infer a latch.
    acc = '0;
    cnt = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c]    = st_q[c];
      st_d[c].we = 1'b0;   // the strobe is a single-cycle pulse

      if (soft_clr) begin
        st_d[c] = '0;
      end else begin
        acc = st_q[c].acc;
        cnt = int'(st_q[c].cnt);

        // Append the elements in arrival order, at the current fill position.
        if (wr_en[c]) begin
          acc[cnt*ELEM_W +: ELEM_W] = din[c*32 +: ELEM_W];
          cnt = cnt + 1;
          if (PACK_MODE != 0) begin
            acc[cnt*ELEM_W +: ELEM_W] = din[c*32+16 +: ELEM_W];
            cnt = cnt + 1;
          end
        end

        // Emit when the line is full, or on flush when anything is held. The
        // accumulator was cleared when the previous line left, so the slots
        // above cnt are already zero and a flushed line comes out zero-padded.
        if ((cnt == BURST_LEN) || (flush && (cnt != 0))) begin
          st_d[c].line = acc;
          st_d[c].we   = 1'b1;
          if (st_q[c].lines != 16'hFFFF) begin
            st_d[c].lines = st_q[c].lines + 16'd1;
          end
          acc = '0;
          cnt = 0;
        end

        // The address moves on in the cycle after a write. If a new line is
        // emitted in this same cycle, it picks up the advanced address, so
        // back-to-back writes still get consecutive addresses.
        if (st_q[c].we) begin
          if (st_q[c].addr == cfg_limit[c*ADDR_W +: ADDR_W]) begin
            st_d[c].addr = '0;
            st_d[c].wrap = 1'b1;
          end else begin
            st_d[c].addr = st_q[c].addr + ADDR_W'(1);
          end
        end

        st_d[c].acc = acc;
        st_d[c].cnt = CNT_W'(cnt);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: the line registers are ordinary flops and not RAM, so they are reset
  // along with the rest of the state, and no stale data can appear on ram_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment only, so every
      // flop samples the value from before the clock edge.
      st_q <= st_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign ram_we[g]                      = st_q[g].we;
    assign ram_addr[g*ADDR_W +: ADDR_W]   = st_q[g].addr;
    assign ram_data[g*LINE_W +: LINE_W]   = st_q[g].line;
    assign elem_cnt[g*8 +: 8]             = 8'(st_q[g].cnt);
    assign wrap_flag[g]                   = st_q[g].wrap;
    assign lines_written[g*16 +: 16]      = st_q[g].lines;
  end

endmodule
